// File: rtl/dispatch_issue_ctrl.sv
// Dispatch issue controller: in-order request FIFO -> one-entry issue stage gated by per-unit credits; push-to-valid 2 cycles,
// s_tready_req = !full, stage holds until the unit's ready. Optional perf counters under DISPATCH_ISSUE_PERF_EN.

module dispatch_issue_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

module dispatch_issue_credit #(
  parameter int MAX = 2,
  parameter int PW  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          take,
  input  logic          done,
  input  logic          refund,
  input  logic [PW-1:0] pend,
  output logic          avail,
  output logic          ahead,
  output logic          ovf
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W:0] MAXV = MAX[W:0];

  logic [W-1:0] cnt;
  logic [W:0]   nxt;

  // A done arriving at max is only legal when this cycle's issue consumes a credit.
  always_comb begin
    nxt = {1'b0, cnt};
    if (done && ((cnt != MAXV[W-1:0]) || take)) nxt = nxt + 1'b1;
    if (refund) nxt = nxt + 1'b1;
    if (take) nxt = nxt - 1'b1;
    if (nxt > MAXV) nxt = MAXV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= MAXV[W-1:0];
    else        cnt <= nxt[W-1:0];
  end

  assign avail = (cnt != '0);
  assign ahead = 32'(cnt) > 32'(pend);
  assign ovf   = done && (cnt == MAXV[W-1:0]) && !take;
endmodule

module dispatch_issue_ctrl #(
  parameter int DEPTH       = 4,
  parameter int ALU_CREDITS = 2,
  parameter int LSU_CREDITS = 4,
  parameter int SP_CREDITS  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_tvalid_req,
  output logic         s_tready_req,
  input  logic [102:0] dispatch_request,
  input  logic         flush,
  output logic         m_tvalid_alu,
  output logic         m_tvalid_lsu,
  output logic         m_tvalid_special,
  input  logic         m_tready_alu,
  input  logic         m_tready_lsu,
  input  logic         m_tready_special,
  output logic [4:0]   issue_warp_id,
  output logic [62:0]  issue_instruction,
  output logic [31:0]  issue_pred,
  input  logic         alu_done,
  input  logic         lsu_done,
  input  logic         special_done,
  output logic         sched_ready_alu,
  output logic         sched_ready_lsu,
  output logic         sched_ready_special,
  output logic [31:0]  err,
  output logic [31:0]  perf_stall_alu,
  output logic [31:0]  perf_stall_lsu,
  output logic [31:0]  perf_stall_special,
  output logic [31:0]  perf_issued
);
  localparam int PW = $clog2(DEPTH + 1);

  typedef enum logic {EMPTY, HOLD} stage_t;

  stage_t        state;
  logic [2:0]    stage_unit;
  logic [102:0]  head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [2:0]    req_unit;
  logic [2:0]    head_unit;
  logic          push;
  logic          accepted;
  logic          load;
  logic [2:0]    m_rdy;
  logic [2:0]    done;
  logic [2:0]    take;
  logic [2:0]    refund;
  logic [2:0]    avail;
  logic [2:0]    ahead;
  logic [2:0]    ovf;
  logic [PW-1:0] pend [3];

  // Unit vectors are indexed by request bit: 2 = ALU, 1 = LSU, 0 = special.
  assign req_unit  = dispatch_request[2:0];
  assign head_unit = head[2:0];
  assign push      = s_tvalid_req && !fifo_full && $onehot(req_unit) && !flush;
  assign m_rdy     = {m_tready_alu, m_tready_lsu, m_tready_special};
  assign done      = {alu_done, lsu_done, special_done};
  assign accepted  = (state == HOLD) && |(stage_unit & m_rdy);
  assign load      = !flush && !fifo_empty && |(head_unit & avail) &&
                     ((state == EMPTY) || accepted);
  assign take      = load ? head_unit : 3'b000;
  assign refund    = (flush && (state == HOLD) && !accepted) ? stage_unit : 3'b000;

  dispatch_issue_fifo #(.W(103), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .clr(flush), .push(push), .din(dispatch_request),
    .pop(load), .head(head), .full(fifo_full), .empty(fifo_empty)
  );

  dispatch_issue_credit #(.MAX(ALU_CREDITS), .PW(PW)) u_cred_alu (
    .clk(clk), .rst_n(rst_n), .take(take[2]), .done(done[2]), .refund(refund[2]),
    .pend(pend[2]), .avail(avail[2]), .ahead(ahead[2]), .ovf(ovf[2])
  );
  dispatch_issue_credit #(.MAX(LSU_CREDITS), .PW(PW)) u_cred_lsu (
    .clk(clk), .rst_n(rst_n), .take(take[1]), .done(done[1]), .refund(refund[1]),
    .pend(pend[1]), .avail(avail[1]), .ahead(ahead[1]), .ovf(ovf[1])
  );
  dispatch_issue_credit #(.MAX(SP_CREDITS), .PW(PW)) u_cred_sp (
    .clk(clk), .rst_n(rst_n), .take(take[0]), .done(done[0]), .refund(refund[0]),
    .pend(pend[0]), .avail(avail[0]), .ahead(ahead[0]), .ovf(ovf[0])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pend[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < 3; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        pend[i] <= pend[i] + PW'(push && req_unit[i]) - PW'(load && head_unit[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= EMPTY;
      stage_unit        <= '0;
      issue_warp_id     <= '0;
      issue_instruction <= '0;
      issue_pred        <= '0;
    end else if (flush) begin
      state      <= EMPTY;
      stage_unit <= '0;
    end else if (load) begin
      state             <= HOLD;
      stage_unit        <= head_unit;
      issue_warp_id     <= head[102:98];
      issue_instruction <= head[97:35];
      issue_pred        <= head[34:3];
    end else if (accepted) begin
      state      <= EMPTY;
      stage_unit <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= '0;
    end else begin
      err <= {28'd0,
              s_tvalid_req && fifo_full,
              |ovf,
              s_tvalid_req && !fifo_full && (req_unit == 3'b000),
              s_tvalid_req && !fifo_full && !$onehot0(req_unit)};
    end
  end

  assign m_tvalid_alu        = stage_unit[2];
  assign m_tvalid_lsu        = stage_unit[1];
  assign m_tvalid_special    = stage_unit[0];
  assign s_tready_req        = !fifo_full;
  assign sched_ready_alu     = ahead[2] && !fifo_full;
  assign sched_ready_lsu     = ahead[1] && !fifo_full;
  assign sched_ready_special = ahead[0] && !fifo_full;

`ifdef DISPATCH_ISSUE_PERF_EN
  logic [31:0] stall_cnt [3];
  logic [31:0] issued_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) stall_cnt[i] <= '0;
      issued_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (!fifo_empty && head_unit[i] && !avail[i]) stall_cnt[i] <= stall_cnt[i] + 32'd1;
      if (accepted) issued_cnt <= issued_cnt + 32'd1;
    end
  end

  assign perf_stall_alu     = stall_cnt[2];
  assign perf_stall_lsu     = stall_cnt[1];
  assign perf_stall_special = stall_cnt[0];
  assign perf_issued        = issued_cnt;
`else
  assign perf_stall_alu     = '0;
  assign perf_stall_lsu     = '0;
  assign perf_stall_special = '0;
  assign perf_issued        = '0;
`endif
endmodule

// File: tb/tb_dispatch_issue_ctrl.sv
// Bench for dispatch_issue_ctrl: queue-based reference model checked every cycle, plus directed literal checks.
module tb_dispatch_issue_ctrl;
  localparam int DEPTH = 4;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         s_tvalid_req = 0;
  logic         s_tready_req;
  logic [102:0] dispatch_request = '0;
  logic         flush = 0;
  logic         m_tvalid_alu, m_tvalid_lsu, m_tvalid_special;
  logic         m_tready_alu = 0, m_tready_lsu = 0, m_tready_special = 0;
  logic [4:0]   issue_warp_id;
  logic [62:0]  issue_instruction;
  logic [31:0]  issue_pred;
  logic         alu_done = 0, lsu_done = 0, special_done = 0;
  logic         sched_ready_alu, sched_ready_lsu, sched_ready_special;
  logic [31:0]  err;
  logic [31:0]  perf_stall_alu, perf_stall_lsu, perf_stall_special, perf_issued;

  int n_vec = 0;
  int n_bad = 0;

  dispatch_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .s_tvalid_req(s_tvalid_req), .s_tready_req(s_tready_req),
    .dispatch_request(dispatch_request), .flush(flush),
    .m_tvalid_alu(m_tvalid_alu), .m_tvalid_lsu(m_tvalid_lsu), .m_tvalid_special(m_tvalid_special),
    .m_tready_alu(m_tready_alu), .m_tready_lsu(m_tready_lsu), .m_tready_special(m_tready_special),
    .issue_warp_id(issue_warp_id), .issue_instruction(issue_instruction), .issue_pred(issue_pred),
    .alu_done(alu_done), .lsu_done(lsu_done), .special_done(special_done),
    .sched_ready_alu(sched_ready_alu), .sched_ready_lsu(sched_ready_lsu),
    .sched_ready_special(sched_ready_special), .err(err),
    .perf_stall_alu(perf_stall_alu), .perf_stall_lsu(perf_stall_lsu),
    .perf_stall_special(perf_stall_special), .perf_issued(perf_issued)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: request queue, one-entry stage, credit counts (index = unit bit: 2 ALU, 1 LSU, 0 SP).
  bit [102:0] q[$];
  bit         stg_v;
  bit [102:0] stg;
  int         cred [3];
  int         maxc [3] = '{1, 4, 2};
  bit [31:0]  err_m;
  bit [31:0]  p_stall [3];
  bit [31:0]  p_iss;

  always @(posedge clk or negedge rst_n) begin : model
    bit full, acc, ld;
    bit [2:0] u, mr, dn;
    bit [31:0] e;
    int h;
    if (!rst_n) begin
      q.delete();
      stg_v = 0;
      stg = '0;
      for (int i = 0; i < 3; i++) begin cred[i] = maxc[i]; p_stall[i] = 0; end
      err_m = 0;
      p_iss = 0;
    end else begin
      full = (q.size() == DEPTH);
      u = dispatch_request[2:0];
      e = 0;
      if (s_tvalid_req && full) e[3] = 1;
      if (s_tvalid_req && !full && u == 3'b000) e[1] = 1;
      if (s_tvalid_req && !full && $countones(u) > 1) e[0] = 1;
      mr = {m_tready_alu, m_tready_lsu, m_tready_special};
      dn = {alu_done, lsu_done, special_done};
      acc = stg_v && ((stg[2:0] & mr) != 3'b000);
      if (acc) p_iss++;
      h = -1;
      if (q.size() > 0) for (int i = 0; i < 3; i++) if (q[0][i]) h = i;
      if (h >= 0 && cred[h] == 0) p_stall[h]++;
      ld = !flush && h >= 0 && cred[h] > 0 && (!stg_v || acc);
      for (int i = 0; i < 3; i++) begin
        if (dn[i]) begin
          if (cred[i] == maxc[i] && !(ld && h == i)) e[2] = 1;
          else cred[i]++;
        end
        if (ld && h == i) cred[i]--;
      end
      if (flush && stg_v && !acc)
        for (int i = 0; i < 3; i++) if (stg[i]) cred[i]++;
      if (flush) begin
        q.delete();
        stg_v = 0;
      end else begin
        if (ld) begin stg = q.pop_front(); stg_v = 1; end
        else if (acc) stg_v = 0;
        if (s_tvalid_req && !full && $countones(u) == 1) q.push_back(dispatch_request);
      end
      err_m = e;
    end
  end

  always @(negedge clk) begin : compare
    int pend [3];
    bit full;
    for (int i = 0; i < 3; i++) pend[i] = 0;
    foreach (q[k]) for (int i = 0; i < 3; i++) if (q[k][i]) pend[i]++;
    full = (q.size() == DEPTH);
    cmp("s_tready_req", s_tready_req, !full);
    cmp("m_tvalid_alu", m_tvalid_alu, stg_v && stg[2]);
    cmp("m_tvalid_lsu", m_tvalid_lsu, stg_v && stg[1]);
    cmp("m_tvalid_special", m_tvalid_special, stg_v && stg[0]);
    cmp("sched_ready_alu", sched_ready_alu, cred[2] > pend[2] && !full);
    cmp("sched_ready_lsu", sched_ready_lsu, cred[1] > pend[1] && !full);
    cmp("sched_ready_special", sched_ready_special, cred[0] > pend[0] && !full);
    cmp("err", err, err_m);
    if (stg_v) begin
      cmp("issue_warp_id", issue_warp_id, stg[102:98]);
      cmp("issue_instruction", issue_instruction, stg[97:35]);
      cmp("issue_pred", issue_pred, stg[34:3]);
    end
`ifdef DISPATCH_ISSUE_PERF_EN
    cmp("perf_stall_alu", perf_stall_alu, p_stall[2]);
    cmp("perf_stall_lsu", perf_stall_lsu, p_stall[1]);
    cmp("perf_stall_special", perf_stall_special, p_stall[0]);
    cmp("perf_issued", perf_issued, p_iss);
`else
    cmp("perf_tied", {perf_stall_alu | perf_stall_lsu, perf_stall_special | perf_issued}, 64'd0);
`endif
  end

  function automatic logic [102:0] mkreq(input logic [4:0] w, input logic [62:0] ins,
                                         input logic [31:0] p, input logic [2:0] u);
    return {w, ins, p, u};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [102:0] r);
    s_tvalid_req = 1;
    dispatch_request = r;
    step();
    s_tvalid_req = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    step();
    cmp("lit_reset_tready", s_tready_req, 1);
    cmp("lit_reset_sched_alu", sched_ready_alu, 1);
    cmp("lit_reset_err", err, 0);
    cmp("lit_reset_warp", issue_warp_id, 0);

    // LSU request: valid two cycles after push, held without ready
    push(mkreq(5'd5, 63'h123, 32'hFFFF_0000, 3'b010));
    cmp("lit_lsu_n1", m_tvalid_lsu, 0);
    step();
    cmp("lit_lsu_n2", m_tvalid_lsu, 1);
    cmp("lit_lsu_warp", issue_warp_id, 5);
    cmp("lit_lsu_pred", issue_pred, 32'hFFFF_0000);
    step(); step();
    cmp("lit_lsu_hold", m_tvalid_lsu, 1);
    m_tready_lsu = 1;
    step();
    cmp("lit_lsu_acc", m_tvalid_lsu, 0);
    m_tready_lsu = 0;
    lsu_done = 1; step(); lsu_done = 0;

    // Three ALU requests against two credits
    m_tready_alu = 1;
    push(mkreq(5'd1, 63'h11, 32'h1, 3'b100));
    push(mkreq(5'd2, 63'h22, 32'h2, 3'b100));
    cmp("lit_alu1_vld", m_tvalid_alu, 1);
    cmp("lit_alu1_warp", issue_warp_id, 1);
    push(mkreq(5'd3, 63'h33, 32'h3, 3'b100));
    cmp("lit_alu2_warp", issue_warp_id, 2);
    step();
    cmp("lit_alu3_blocked", m_tvalid_alu, 0);
    cmp("lit_alu_sched", sched_ready_alu, 0);
    step();
    alu_done = 1; step(); alu_done = 0;
    cmp("lit_alu_done_n", m_tvalid_alu, 0);
    step();
    cmp("lit_alu3_vld", m_tvalid_alu, 1);
    cmp("lit_alu3_warp", issue_warp_id, 3);
    step();
    alu_done = 1; step(); step(); alu_done = 0;
    m_tready_alu = 0;

    // Illegal unit encodings
    push(mkreq(5'd4, 63'h44, 32'h4, 3'b011));
    cmp("lit_err_multi", err, 32'h1);
    push(mkreq(5'd4, 63'h44, 32'h4, 3'b000));
    cmp("lit_err_none", err, 32'h2);
    step();
    cmp("lit_err_clear", err, 0);
    cmp("lit_err_no_vld", {m_tvalid_alu, m_tvalid_lsu, m_tvalid_special}, 0);

    // Fill with special-unit requests (one credit)
    for (int i = 0; i < 5; i++) push(mkreq(5'(10 + i), 63'(i), 32'(i), 3'b001));
    cmp("lit_full_tready", s_tready_req, 0);
    cmp("lit_full_sched_sp", sched_ready_special, 0);
    push(mkreq(5'd15, 63'h55, 32'h5, 3'b001));
    cmp("lit_full_err3", err, 32'h8);
    step();
`ifdef DISPATCH_ISSUE_PERF_EN
    cmp("lit_perf_stall_sp", perf_stall_special, 5);
`endif
    m_tready_special = 1;
    step();
    m_tready_special = 0;
    cmp("lit_sp_acc", m_tvalid_special, 0);
    cmp("lit_sp_still_full", s_tready_req, 0);
`ifdef DISPATCH_ISSUE_PERF_EN
    cmp("lit_perf_issued", perf_issued, 5);
`endif
    special_done = 1; step(); special_done = 0;
    cmp("lit_sp_cred_back", s_tready_req, 0);
    step();
    cmp("lit_pop_tready", s_tready_req, 1);
    cmp("lit_sp1_warp", issue_warp_id, 11);

    // Flush with stage in HOLD, FIFO occupied, and a simultaneous push
    flush = 1;
    push(mkreq(5'd20, 63'h66, 32'h6, 3'b010));
    flush = 0;
    cmp("lit_flush_vld", {m_tvalid_alu, m_tvalid_lsu, m_tvalid_special}, 0);
    cmp("lit_flush_tready", s_tready_req, 1);
    cmp("lit_flush_sched_sp", sched_ready_special, 1);
    step();
    cmp("lit_flush_dropped", m_tvalid_lsu, 0);
    special_done = 1; step(); special_done = 0;
    cmp("lit_spurious_done", err, 32'h4);
    step();
    cmp("lit_err2_clear", err, 0);

    // Reset in the middle of traffic
    m_tready_lsu = 1;
    push(mkreq(5'd7, 63'h77, 32'h7, 3'b010));
    step(); step();
    m_tready_lsu = 0;
    #1 rst_n = 0;
    #1;
    cmp("lit_rst_vld", m_tvalid_lsu, 0);
    step();
    rst_n = 1;
    step();
`ifdef DISPATCH_ISSUE_PERF_EN
    cmp("lit_rst_perf", perf_issued, 0);
`endif
    lsu_done = 1; step(); lsu_done = 0;
    cmp("lit_rst_late_done", err, 32'h4);
    step();
    cmp("lit_rst_err_clear", err, 0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
